// File: rtl/lcd_fill_engine_pkg.sv
// Shared LCD command bytes, fill-engine state encoding and the header byte selector
// used by the rectangle-fill byte streamer.
package lcd_fill_engine_pkg;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    localparam logic [3:0] HDR_LAST = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HDR   = 2'd2,
        PIX   = 2'd3
    } fill_state_e;

    // Returns {dc, data} for header position idx (CASET + 4 params, RASET + 4 params, RAMWR).
    function automatic logic [8:0] hdr_byte(input logic [3:0]  idx,
                                            input logic [15:0] xs,
                                            input logic [15:0] xe,
                                            input logic [15:0] ys,
                                            input logic [15:0] ye);
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, CMD_CASET};
            4'd1:    b = {1'b1, xs[15:8]};
            4'd2:    b = {1'b1, xs[7:0]};
            4'd3:    b = {1'b1, xe[15:8]};
            4'd4:    b = {1'b1, xe[7:0]};
            4'd5:    b = {1'b0, CMD_RASET};
            4'd6:    b = {1'b1, ys[15:8]};
            4'd7:    b = {1'b1, ys[7:0]};
            4'd8:    b = {1'b1, ye[15:8]};
            4'd9:    b = {1'b1, ye[7:0]};
            4'd10:   b = {1'b0, CMD_RAMWR};
            default: b = {1'b0, 8'h00};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_fill_engine_if.sv
// Request and byte-stream bundle of the LCD fill engine; master is the requester /
// byte consumer side, slave is the engine.
interface lcd_fill_engine_if #(
    parameter int COORD_W = 9
) ();
    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_x0;
    logic [COORD_W-1:0] req_y0;
    logic [COORD_W-1:0] req_x1;
    logic [COORD_W-1:0] req_y1;
    logic [15:0]        req_color;
    logic               tx_valid;
    logic               tx_ready;
    logic [7:0]         tx_data;
    logic               tx_dc;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output req_valid, req_x0, req_y0, req_x1, req_y1, req_color, tx_ready,
        input  req_ready, tx_valid, tx_data, tx_dc, busy, done, err
    );

    modport slave (
        input  req_valid, req_x0, req_y0, req_x1, req_y1, req_color, tx_ready,
        output req_ready, tx_valid, tx_data, tx_dc, busy, done, err
    );
endinterface

// File: rtl/lcd_fill_engine.sv
// Rectangle fill byte streamer: turns one (x0,y0,x1,y1,colour) request into
// CASET/RASET/RAMWR header bytes followed by 2N RGB565 pixel bytes.
module lcd_fill_engine
    import lcd_fill_engine_pkg::*;
#(
    parameter int WIDTH    = 240,
    parameter int HEIGHT   = 240,
    parameter int COORD_W  = 9,
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 0
) (
    input  logic             clk,
    input  logic             reset,
    lcd_fill_engine_if.slave bus
);

    localparam int PCNT_W = $clog2(WIDTH * HEIGHT + 1);
    localparam int AREA_W = 2 * COORD_W + 2;
    localparam logic [COORD_W:0]    WIDTH_C  = (COORD_W + 1)'(WIDTH);
    localparam logic [COORD_W:0]    HEIGHT_C = (COORD_W + 1)'(HEIGHT);
    localparam logic [15:0]         X_OFF_C  = 16'(X_OFFSET);
    localparam logic [15:0]         Y_OFF_C  = 16'(Y_OFFSET);
    localparam logic [PCNT_W-1:0]   ONE_PIX  = PCNT_W'(1);

    fill_state_e        state_r;
    logic [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;
    logic [15:0]        color_r;
    logic [PCNT_W-1:0]  n_r;
    logic [PCNT_W-1:0]  pix_rem_r;
    logic               phase_r;
    logic [3:0]         idx_r;
    logic               req_ready_r;
    logic               tx_valid_r;
    logic [7:0]         tx_data_r;
    logic               tx_dc_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic [COORD_W:0]   dx_s, dy_s;
    logic [AREA_W-1:0]  area_s;
    logic               legal_s;
    logic [15:0]        xs_s, xe_s, ys_s, ye_s;
    logic [8:0]         hdr_next_s;
    logic               tx_fire_s;

    // Legality, pixel count and offset coordinates derived from the latched request.
    always_comb begin
        dx_s       = {1'b0, x1_r} - {1'b0, x0_r} + {{COORD_W{1'b0}}, 1'b1};
        dy_s       = {1'b0, y1_r} - {1'b0, y0_r} + {{COORD_W{1'b0}}, 1'b1};
        area_s     = AREA_W'(dx_s) * AREA_W'(dy_s);
        legal_s    = (x0_r <= x1_r) && (y0_r <= y1_r) &&
                     ({1'b0, x1_r} < WIDTH_C) && ({1'b0, y1_r} < HEIGHT_C);
        xs_s       = 16'(x0_r) + X_OFF_C;
        xe_s       = 16'(x1_r) + X_OFF_C;
        ys_s       = 16'(y0_r) + Y_OFF_C;
        ye_s       = 16'(y1_r) + Y_OFF_C;
        hdr_next_s = hdr_byte(idx_r + 4'd1, xs_s, xe_s, ys_s, ye_s);
        tx_fire_s  = tx_valid_r & bus.tx_ready;
    end

    // Request/stream sequencer; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            x0_r        <= '0;
            y0_r        <= '0;
            x1_r        <= '0;
            y1_r        <= '0;
            color_r     <= 16'h0000;
            n_r         <= '0;
            pix_rem_r   <= '0;
            phase_r     <= 1'b0;
            idx_r       <= 4'd0;
            req_ready_r <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            tx_dc_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        x0_r        <= bus.req_x0;
                        y0_r        <= bus.req_y0;
                        x1_r        <= bus.req_x1;
                        y1_r        <= bus.req_y1;
                        color_r     <= bus.req_color;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= CHECK;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                CHECK: begin
                    if (legal_s) begin
                        n_r        <= area_s[PCNT_W-1:0];
                        idx_r      <= 4'd0;
                        tx_valid_r <= 1'b1;
                        tx_dc_r    <= 1'b0;
                        tx_data_r  <= CMD_CASET;
                        state_r    <= HDR;
                    end else begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                HDR: begin
                    if (tx_fire_s) begin
                        if (idx_r == HDR_LAST) begin
                            pix_rem_r <= n_r;
                            phase_r   <= 1'b0;
                            tx_dc_r   <= 1'b1;
                            tx_data_r <= color_r[15:8];
                            state_r   <= PIX;
                        end else begin
                            idx_r     <= idx_r + 4'd1;
                            tx_dc_r   <= hdr_next_s[8];
                            tx_data_r <= hdr_next_s[7:0];
                        end
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                PIX: begin
                    if (tx_fire_s) begin
                        if (!phase_r) begin
                            phase_r   <= 1'b1;
                            tx_data_r <= color_r[7:0];
                        end else if (pix_rem_r == ONE_PIX) begin
                            tx_valid_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= IDLE;
                        end else begin
                            pix_rem_r <= pix_rem_r - ONE_PIX;
                            phase_r   <= 1'b0;
                            tx_data_r <= color_r[15:8];
                        end
                    end else begin
                        phase_r <= phase_r;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.tx_valid  = tx_valid_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_dc     = tx_dc_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_lcd_fill_engine.sv
// Bench for lcd_fill_engine: directed and random fill requests with random tx_ready
// stalls, compared against a byte-queue reference built from the request fields.
module tb_lcd_fill_engine;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_fill_engine_if #(.COORD_W(CW)) bus ();

    lcd_fill_engine #(
        .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .X_OFFSET(0), .Y_OFFSET(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference stream: header bytes then N pixels of {hi, lo}; empty when illegal.
    function automatic bit build_expected(input int x0, input int y0, input int x1, input int y1,
                                          input logic [15:0] col);
        logic [15:0] xs, xe, ys, ye;
        int n;
        exp_q.delete();
        if (x0 > x1 || y0 > y1 || x1 >= W || y1 >= H) return 1'b0;
        xs = 16'(x0); xe = 16'(x1); ys = 16'(y0); ye = 16'(y1);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, xs[15:8]}); exp_q.push_back({1'b1, xs[7:0]});
        exp_q.push_back({1'b1, xe[15:8]}); exp_q.push_back({1'b1, xe[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, ys[15:8]}); exp_q.push_back({1'b1, ys[7:0]});
        exp_q.push_back({1'b1, ye[15:8]}); exp_q.push_back({1'b1, ye[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        n = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int p = 0; p < n; p++) begin
            exp_q.push_back({1'b1, col[15:8]});
            exp_q.push_back({1'b1, col[7:0]});
        end
        return 1'b1;
    endfunction

    task automatic run_req(input int x0, input int y0, input int x1, input int y1,
                           input logic [15:0] col, input int stall_pct, input int abort_at);
        bit         legal, fin, stalled, r;
        int         got, cyc, bound, wait_n;
        logic [8:0] prev, cur;
        legal  = build_expected(x0, y0, x1, y1, col);
        bound  = 4 * exp_q.size() + 20;
        wait_n = 0;
        while (!bus.req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_x0 = CW'(x0); bus.req_y0 = CW'(y0);
        bus.req_x1 = CW'(x1); bus.req_y1 = CW'(y1);
        bus.req_color = col;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_x0 = CW'($urandom); bus.req_y0 = CW'($urandom);
        bus.req_x1 = CW'($urandom); bus.req_y1 = CW'($urandom);
        bus.req_color = 16'($urandom);
        got = 0; cyc = 0; fin = 1'b0; stalled = 1'b0; prev = 9'h000;
        while (!fin && cyc < bound) begin
            if (abort_at >= 0 && got == abort_at) break;
            if (bus.done || bus.err) begin
                fin = 1'b1;
            end else begin
                check_eq("busy_in_stream", 32'(bus.busy), 32'd1);
                check_eq("req_ready_low", 32'(bus.req_ready), 32'd0);
                cur = {bus.tx_dc, bus.tx_data};
                if (stalled) begin
                    check_eq("hold_valid", 32'(bus.tx_valid), 32'd1);
                    check_eq("hold_byte", 32'(cur), 32'(prev));
                end
                if (bus.tx_valid) begin
                    r = ($urandom_range(0, 99) >= stall_pct);
                    bus.tx_ready = r;
                    if (r) begin
                        if (got < exp_q.size())
                            check_eq($sformatf("byte%0d", got), 32'(cur), 32'(exp_q[got]));
                        else
                            check_eq("extra_byte", 32'(got), 32'(exp_q.size()));
                        got++;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        prev    = cur;
                    end
                end else begin
                    bus.tx_ready = 1'($urandom_range(0, 1));
                    stalled = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (abort_at >= 0) begin
            check_eq("abort_point", 32'(got), 32'(abort_at));
            reset = 1'b1;
            bus.tx_ready = 1'b0;
            #1;
            check_eq("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
            check_eq("abort_busy", 32'(bus.busy), 32'd0);
            check_eq("abort_done", 32'(bus.done), 32'd0);
            check_eq("abort_err", 32'(bus.err), 32'd0);
            check_eq("abort_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check_eq("post_abort_ready", 32'(bus.req_ready), 32'd1);
            check_eq("post_abort_valid", 32'(bus.tx_valid), 32'd0);
            check_eq("post_abort_done", 32'(bus.done), 32'd0);
            return;
        end
        check_eq("stream_finished", 32'(fin), 32'd1);
        if (legal) begin
            check_eq("done_pulse", 32'(bus.done), 32'd1);
            check_eq("no_err", 32'(bus.err), 32'd0);
            check_eq("byte_count", 32'(got), 32'(exp_q.size()));
            check_eq("ready_at_done", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            check_eq("done_one_cycle", 32'(bus.done), 32'd0);
            check_eq("ready_after_done", 32'(bus.req_ready), 32'd1);
            check_eq("valid_after_done", 32'(bus.tx_valid), 32'd0);
            check_eq("busy_after_done", 32'(bus.busy), 32'd0);
        end else begin
            check_eq("err_pulse", 32'(bus.err), 32'd1);
            check_eq("no_done", 32'(bus.done), 32'd0);
            check_eq("err_latency", 32'(cyc), 32'd1);
            check_eq("illegal_bytes", 32'(got), 32'd0);
            @(negedge clk);
            check_eq("err_one_cycle", 32'(bus.err), 32'd0);
            check_eq("ready_after_err", 32'(bus.req_ready), 32'd1);
            check_eq("valid_after_err", 32'(bus.tx_valid), 32'd0);
        end
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_x0    = '0;
        bus.req_y0    = '0;
        bus.req_x1    = '0;
        bus.req_y1    = '0;
        bus.req_color = 16'h0000;
        bus.tx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_req_ready", 32'(bus.req_ready), 32'd1);

        run_req(0, 0, 0, 0, 16'hF800, 0, -1);
        run_req(10, 20, 12, 21, 16'h07E0, 0, -1);
        run_req(10, 20, 12, 21, 16'h07E0, 50, -1);
        run_req(5, 0, 4, 0, 16'h1234, 0, -1);
        run_req(0, 0, W, 0, 16'h1234, 0, -1);
        run_req(0, 0, 0, H, 16'h1234, 30, -1);
        run_req(0, 0, W - 1, H - 1, 16'h001F, 0, -1);
        run_req(10, 20, 12, 21, 16'h07E0, 0, 11 + 4);
        run_req(1, 1, 1, 1, 16'hA5C3, 20, -1);

        for (int t = 0; t < 16; t++) begin
            rx0 = $urandom_range(0, W - 1);
            ry0 = $urandom_range(0, H - 1);
            rx1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, W + 4) : rx0 + $urandom_range(0, 3);
            ry1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, H + 4) : ry0 + $urandom_range(0, 3);
            run_req(rx0, ry0, rx1, ry1, 16'($urandom), $urandom_range(0, 60), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
